// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a framed little-endian byte stream into instruction-memory word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR-of-payload checksum byte before DONE.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SPACE_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  cpu_rst_o
);

  localparam int unsigned WCNT_W    = SPACE_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** SPACE_WIDTH);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

  state_t            state;
  logic [7:0]        hdr_lo;
  logic [WCNT_W-1:0] n_words;
  logic [WCNT_W-1:0] word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        accept;
  logic [15:0] hdr_n;

  assign accept = byte_valid_i & byte_ready_o;
  assign hdr_n  = {byte_data_i, hdr_lo};

  // Single-process FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      hdr_lo       <= '0;
      n_words      <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      acc          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      cpu_rst_o    <= 1'b1;
    end else begin
      we_o <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            state        <= HDR0;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            cpu_rst_o    <= 1'b1;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            acc          <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        HDR0: begin
          if (accept) begin
            hdr_lo <= byte_data_i;
            state  <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state        <= CHK;
`else
              state        <= DONE;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              cpu_rst_o    <= 1'b0;
`endif
            end else if ({1'b0, hdr_n} > MAX_WORDS) begin
              state        <= ERR;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              err_o        <= 1'b1;
            end else begin
              state   <= DATA;
              n_words <= hdr_n[WCNT_W-1:0];
            end
          end
        end
        DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data_i;
`endif
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: acc[7:0]   <= byte_data_i;
              2'd1: acc[15:8]  <= byte_data_i;
              2'd2: acc[23:16] <= byte_data_i;
              default: begin
                // Fourth byte completes the word: write it next cycle without stalling the stream.
                we_o     <= 1'b1;
                waddr_o  <= ADDR_WIDTH'({word_cnt, 2'b00});
                wdata_o  <= DATA_WIDTH'({byte_data_i, acc});
                acc      <= '0;
                word_cnt <= word_cnt + WCNT_W'(1);
                if (word_cnt == n_words - WCNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state        <= CHK;
`else
                  state        <= DONE;
                  byte_ready_o <= 1'b0;
                  busy_o       <= 1'b0;
                  done_o       <= 1'b1;
                  cpu_rst_o    <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            if (byte_data_i == csum) begin
              state     <= DONE;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
            end else begin
              state <= ERR;
              err_o <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for a two-word image plus hand sequences for size limits,
// stalls, mid-load start/reset and (when IMEM_LOADER_CHECKSUM_EN is defined) checksum handling.
module tb_imem_loader;
  localparam int unsigned ADDR_WIDTH  = 10;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned SPACE_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_i, start_i, byte_valid_i;
  logic [7:0]            byte_data_i;
  logic                  byte_ready_o, we_o, busy_o, done_o, err_o, cpu_rst_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;

  imem_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SPACE_WIDTH(SPACE_WIDTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .byte_valid_i(byte_valid_i),
    .byte_data_i (byte_data_i),
    .byte_ready_o(byte_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cpu_rst_o   (cpu_rst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        crst;
  } vec_t;

  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  xsum;
  logic [7:0]  img[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, wait past the edge, log any write pulse.
  task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
    rst_i = r; start_i = s; byte_valid_i = v; byte_data_i = d;
    @(posedge clk);
    #1;
    if (we_o) begin
      wa_q.push_back(32'(waddr_o));
      wd_q.push_back(32'(wdata_o));
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (!byte_ready_o && n < 16) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    if (!byte_ready_o) chk("ready_timeout", 32'(byte_ready_o), 32'd1);
    else step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d, input logic rdy, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd, input logic busy, input logic done,
                     input logic crst);
    vec_t e;
    e.s = s; e.v = v; e.d = d; e.rdy = rdy; e.we = we; e.wa = wa; e.wd = wd;
    e.busy = busy; e.done = done; e.crst = crst;
    tbl.push_back(e);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    xsum = 8'h00;
    foreach (img[i]) xsum = xsum ^ img[i];

    // Two-word image, one row per clock; row 0 also offers a byte in IDLE, which must not be taken.
    add(1, 1, 8'hFF, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h02, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h13, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 1, 32'h0, 32'h0000_0013, 1, 0, 1);
    add(0, 1, 8'h93, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 8'h10, 1, 0, 0, 0, 1, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(0, 1, 8'h00, 1, 1, 32'h4, 32'h0010_0093, 1, 0, 1);
    add(0, 1, 8'h90, 0, 0, 0, 0, 0, 1, 0);
`else
    add(0, 1, 8'h00, 0, 1, 32'h4, 32'h0010_0093, 0, 1, 0);
`endif
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0);

    rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00;

    // Reset for two cycles, with start_i asserted to show reset wins.
    step(1, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("rst cpu_rst", 32'(cpu_rst_o), 1);
    chk("rst ready", 32'(byte_ready_o), 0);
    chk("rst we", 32'(we_o), 0);
    chk("rst done", 32'(done_o), 0);
    chk("rst err", 32'(err_o), 0);
    chk("rst busy", 32'(busy_o), 0);
    clear_log();

    foreach (tbl[i]) begin
      step(0, tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("t2[%0d] ready", i), 32'(byte_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("t2[%0d] we", i), 32'(we_o), 32'(tbl[i].we));
      chk($sformatf("t2[%0d] busy", i), 32'(busy_o), 32'(tbl[i].busy));
      chk($sformatf("t2[%0d] done", i), 32'(done_o), 32'(tbl[i].done));
      chk($sformatf("t2[%0d] cpu_rst", i), 32'(cpu_rst_o), 32'(tbl[i].crst));
      chk($sformatf("t2[%0d] err", i), 32'(err_o), 0);
      if (tbl[i].we) begin
        chk($sformatf("t2[%0d] waddr", i), 32'(waddr_o), tbl[i].wa);
        chk($sformatf("t2[%0d] wdata", i), 32'(wdata_o), tbl[i].wd);
      end
    end
    chk("t2 write count", 32'(wa_q.size()), 2);

    // Maximum image: 256 words; start from DONE with a simultaneous byte that must be dropped.
    clear_log();
    step(0, 1, 1, 8'h55);
    chk("t3 restart busy", 32'(busy_o), 1);
    chk("t3 restart done", 32'(done_o), 0);
    chk("t3 restart cpu_rst", 32'(cpu_rst_o), 1);
    send_byte(8'h00);
    send_byte(8'h01);
    xsum = 8'h00;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      send_byte(kb);
      send_byte(~kb);
      send_byte(8'h3C);
      send_byte(kb + 8'd1);
      xsum = xsum ^ kb ^ ~kb ^ 8'h3C ^ (kb + 8'd1);
    end
    chk("t3 last waddr", 32'(waddr_o), 32'h3FC);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xsum);
`endif
    chk("t3 done", 32'(done_o), 1);
    chk("t3 cpu_rst", 32'(cpu_rst_o), 0);
    chk("t3 write count", 32'(wa_q.size()), 256);
    for (int k = 0; k < 256 && k < wa_q.size(); k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      chk($sformatf("t3 waddr[%0d]", k), wa_q[k], 32'(k * 4));
      chk($sformatf("t3 wdata[%0d]", k), wd_q[k], {kb + 8'd1, 8'h3C, ~kb, kb});
    end

    // Oversized image: N=257 must fail right after the header.
    clear_log();
    step(0, 1, 0, 8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    chk("t3b err", 32'(err_o), 1);
    chk("t3b ready", 32'(byte_ready_o), 0);
    chk("t3b done", 32'(done_o), 0);
    step(0, 0, 1, 8'hAB);
    step(0, 0, 1, 8'hCD);
    chk("t3b cpu_rst", 32'(cpu_rst_o), 1);
    chk("t3b no writes", 32'(wa_q.size()), 0);

    // Valid toggling every cycle, plus a start pulse mid-load that must be ignored.
    clear_log();
    step(0, 1, 0, 8'h00);
    chk("t4 err cleared", 32'(err_o), 0);
    chk("t4 busy", 32'(busy_o), 1);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, img[i]);
      step(0, (i == 3), 0, 8'h00);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h90);
`endif
    chk("t4 done", 32'(done_o), 1);
    chk("t4 busy end", 32'(busy_o), 0);
    chk("t4 write count", 32'(wa_q.size()), 2);
    if (wa_q.size() == 2) begin
      chk("t4 waddr0", wa_q[0], 32'h0);
      chk("t4 wdata0", wd_q[0], 32'h0000_0013);
      chk("t4 waddr1", wa_q[1], 32'h4);
      chk("t4 wdata1", wd_q[1], 32'h0010_0093);
    end

    // Reset after six payload bytes: only word 0 reaches memory.
    clear_log();
    step(0, 1, 0, 8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    step(1, 0, 0, 8'h00);
    chk("t5 ready", 32'(byte_ready_o), 0);
    chk("t5 busy", 32'(busy_o), 0);
    chk("t5 cpu_rst", 32'(cpu_rst_o), 1);
    chk("t5 waddr", 32'(waddr_o), 0);
    chk("t5 wdata", 32'(wdata_o), 0);
    step(0, 0, 1, 8'hAA);
    step(0, 0, 1, 8'hBB);
    chk("t5 still idle", 32'(busy_o), 0);
    chk("t5 write count", 32'(wa_q.size()), 1);
    if (wa_q.size() >= 1) begin
      chk("t5 waddr0", wa_q[0], 32'h0);
      chk("t5 wdata0", wd_q[0], 32'h0000_0013);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words are written but the load fails.
    clear_log();
    step(0, 1, 0, 8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    send_byte(8'h00);
    chk("t6 err", 32'(err_o), 1);
    chk("t6 done", 32'(done_o), 0);
    chk("t6 cpu_rst", 32'(cpu_rst_o), 1);
    chk("t6 write count", 32'(wa_q.size()), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
